lc3_mem_ctrl: RTL and testbench

Memory-side responder for the LC3 core's memory port. Accepts read/write requests qualified by `memEN`/`memWE`, serves them from an internal word-addressed RAM after a configurable number of wait states, and returns `memory_dout` with a one-cycle `memRDY` completion pulse. It sits directly downstream of the core's memory signals, and is the DUT-side counterpart of the bench driver. A side-band load port lets the bench preload program images without going through the core.

---
 rtl/lc3_mem_if.sv | 24 ++
 rtl/lc3_mem_ctrl.sv | 153 +++++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_if.sv
// LC3 memory-port bundle: core request/response signals plus the backdoor load strobe.
// The master is the core (or bench); the slave is the memory controller.
interface lc3_mem_if;
    logic        memEN;
    logic        memWE;
    logic [15:0] memory_addr;
    logic [15:0] memory_din;
    logic [15:0] memory_dout;
    logic        memRDY;
    logic        mem_oor;
    logic        load_en;
    logic [15:0] load_addr;
    logic [15:0] load_data;

    modport master (
        output memEN, memWE, memory_addr, memory_din, load_en, load_addr, load_data,
        input  memory_dout, memRDY, mem_oor
    );

    modport slave (
        input  memEN, memWE, memory_addr, memory_din, load_en, load_addr, load_data,
        output memory_dout, memRDY, mem_oor
    );
endinterface

// File: rtl/lc3_mem_ctrl.sv
// Memory-side responder for the LC3 memory port: word-addressed RAM behind a
// fixed number of wait states, with a one-cycle memRDY completion pulse.
module lc3_mem_ctrl #(
    parameter int DEPTH_LOG2  = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    lc3_mem_if.slave   bus,
    output logic [1:0] dbg_state
);
    // Handshake: a request is memEN held high with addr/WE/din stable; it is
    // accepted on an IDLE edge with load_en low and completes with exactly one
    // memRDY cycle. The requester must drop memEN on the edge that sees memRDY.
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] din_q, din_d;
    logic [15:0] dout_q, dout_d;
    logic        we_q, we_d;
    logic        oor_q, oor_d;

    logic [15:0] ram [DEPTH];

    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_widx;
    logic [15:0]           ram_wdata;
    logic                  enter_resp;
    logic [15:0]           op_addr;
    logic [15:0]           op_din;
    logic                  op_we;
    logic                  op_in_range;
    logic                  load_in_range;

    function automatic logic in_range(input logic [15:0] a);
        logic [31:0] wide;
        wide = {16'd0, a} >> DEPTH_LOG2;
        return wide == 32'd0;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        din_d      = din_q;
        dout_d     = dout_q;
        oor_d      = oor_q;
        ram_we     = 1'b0;
        ram_widx   = '0;
        ram_wdata  = '0;
        enter_resp = 1'b0;

        // With zero wait states the operation completes on the accepting edge,
        // so it must act on the live inputs rather than the latched copy.
        op_addr       = (state_q == S_IDLE) ? bus.memory_addr : addr_q;
        op_din        = (state_q == S_IDLE) ? bus.memory_din  : din_q;
        op_we         = (state_q == S_IDLE) ? bus.memWE       : we_q;
        op_in_range   = in_range(op_addr);
        load_in_range = in_range(bus.load_addr);

        case (state_q)
            S_IDLE: begin
                if (bus.load_en) begin
                    if (load_in_range) begin
                        ram_we    = 1'b1;
                        ram_widx  = bus.load_addr[DEPTH_LOG2-1:0];
                        ram_wdata = bus.load_data;
                    end
                end else if (bus.memEN) begin
                    addr_d = bus.memory_addr;
                    we_d   = bus.memWE;
                    din_d  = bus.memory_din;
                    if (WAIT_CYCLES == 0) begin
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The RESP-entry edge is the commit point: a reset before it drops the write.
        if (enter_resp) begin
            state_d = S_RESP;
            oor_d   = ~op_in_range;
            if (op_we) begin
                if (op_in_range) begin
                    ram_we    = 1'b1;
                    ram_widx  = op_addr[DEPTH_LOG2-1:0];
                    ram_wdata = op_din;
                end
            end else begin
                dout_d = op_in_range ? ram[op_addr[DEPTH_LOG2-1:0]] : 16'h0000;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            we_q    <= 1'b0;
            din_q   <= 16'h0000;
            dout_q  <= 16'h0000;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            oor_q   <= oor_d;
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_widx] <= ram_wdata;
        end
    end

    assign bus.memRDY      = (state_q == S_RESP);
    assign bus.mem_oor     = (state_q == S_RESP) && oor_q;
    assign bus.memory_dout = dout_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Bench for lc3_mem_ctrl: two instances (2 wait states / 4K words, and 0 wait
// states / 64K words) checked every cycle against a timeline-level memory model.
module tb_lc3_mem_ctrl;
  localparam int W_A = 2;
  localparam int D_A = 12;
  localparam int W_B = 0;
  localparam int D_B = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lc3_mem_if if_a ();
  lc3_mem_if if_b ();
  logic [1:0] dbg_a, dbg_b;

  lc3_mem_ctrl #(.DEPTH_LOG2(D_A), .WAIT_CYCLES(W_A)) u_dut_a (
    .clk(clk), .rst(rst), .bus(if_a), .dbg_state(dbg_a));
  lc3_mem_ctrl #(.DEPTH_LOG2(D_B), .WAIT_CYCLES(W_B)) u_dut_b (
    .clk(clk), .rst(rst), .bus(if_b), .dbg_state(dbg_b));

  logic        en [2];
  logic        we [2];
  logic        ld [2];
  logic [15:0] addr [2];
  logic [15:0] din [2];
  logic [15:0] ld_addr [2];
  logic [15:0] ld_data [2];
  logic        rdy_s [2];
  logic        oor_s [2];
  logic [15:0] dout_s [2];

  assign if_a.memEN = en[0];        assign if_b.memEN = en[1];
  assign if_a.memWE = we[0];        assign if_b.memWE = we[1];
  assign if_a.memory_addr = addr[0]; assign if_b.memory_addr = addr[1];
  assign if_a.memory_din = din[0];  assign if_b.memory_din = din[1];
  assign if_a.load_en = ld[0];      assign if_b.load_en = ld[1];
  assign if_a.load_addr = ld_addr[0]; assign if_b.load_addr = ld_addr[1];
  assign if_a.load_data = ld_data[0]; assign if_b.load_data = ld_data[1];
  assign rdy_s[0] = if_a.memRDY;    assign rdy_s[1] = if_b.memRDY;
  assign oor_s[0] = if_a.mem_oor;   assign oor_s[1] = if_b.mem_oor;
  assign dout_s[0] = if_a.memory_dout; assign dout_s[1] = if_b.memory_dout;

  int total = 0;
  int bad = 0;

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          ek = 0;
  int          next_free [2];
  int          rdy_at [2];
  bit          pend [2];
  bit          p_we [2];
  logic [15:0] p_addr [2];
  logic [15:0] p_din [2];
  logic [15:0] m_dout [2];
  bit          m_known [2];
  bit          m_rdy [2];
  bit          m_oor [2];
  logic [15:0] mem_m [int];

  function automatic int wc(int i);
    return (i == 0) ? W_A : W_B;
  endfunction

  function automatic bit inr(int i, logic [15:0] a);
    int d;
    d = (i == 0) ? D_A : D_B;
    return (int'(a) >> d) == 0;
  endfunction

  task automatic model_reset(int i);
    pend[i] = 0; m_rdy[i] = 0; m_oor[i] = 0;
    m_dout[i] = 16'h0000; m_known[i] = 1; next_free[i] = 0;
  endtask

  // Free from edge next_free on; a request accepted at edge k completes at
  // edge k+W and the controller can accept again at edge k+W+2.
  task automatic model_step(int i);
    int key;
    m_rdy[i] = 0;
    if (ek >= next_free[i]) begin
      if (ld[i]) begin
        if (inr(i, ld_addr[i])) mem_m[i * 65536 + int'(ld_addr[i])] = ld_data[i];
      end else if (en[i]) begin
        pend[i] = 1; p_we[i] = we[i]; p_addr[i] = addr[i]; p_din[i] = din[i];
        rdy_at[i] = ek + wc(i);
        next_free[i] = ek + wc(i) + 2;
      end
    end
    if (pend[i] && ek == rdy_at[i]) begin
      pend[i] = 0;
      m_rdy[i] = 1;
      m_oor[i] = !inr(i, p_addr[i]);
      key = i * 65536 + int'(p_addr[i]);
      if (p_we[i]) begin
        if (inr(i, p_addr[i])) mem_m[key] = p_din[i];
      end else if (!inr(i, p_addr[i])) begin
        m_dout[i] = 16'h0000; m_known[i] = 1;
      end else if (mem_m.exists(key)) begin
        m_dout[i] = mem_m[key]; m_known[i] = 1;
      end else begin
        m_known[i] = 0;
      end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    for (int i = 0; i < 2; i++) model_reset(i);
    forever begin
      @(posedge clk);
      ek++;
      if (rst === 1'b1) for (int i = 0; i < 2; i++) model_step(i);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst !== 1'b1) model_reset(i);
        check($sformatf("rdy%0d@%0d", i, ek), 16'(rdy_s[i]), 16'(m_rdy[i]));
        check($sformatf("oor%0d@%0d", i, ek), 16'(oor_s[i]), 16'(m_rdy[i] & m_oor[i]));
        if (m_known[i]) check($sformatf("dout%0d@%0d", i, ek), dout_s[i], m_dout[i]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_req(int i, bit w, logic [15:0] a, logic [15:0] d);
    en[i] = 1'b1; we[i] = w; addr[i] = a; din[i] = d;
  endtask

  // Returns cycles from the accepting edge to the memRDY cycle, plus captured outputs.
  task automatic wait_rdy(int i, output int lat, output logic [15:0] dout, output logic oor);
    int  n;
    bit  found;
    n = 0; found = 0; dout = 16'h0; oor = 1'b0;
    while (!found && n < 60) begin
      @(negedge clk);
      n++;
      if (rdy_s[i] === 1'b1) begin
        found = 1; dout = dout_s[i]; oor = oor_s[i];
      end
    end
    lat = n - 1;
    if (!found) begin
      total++; bad++;
      $display("FAIL rdy_timeout dut%0d: got no memRDY want memRDY within 60 cycles", i);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(int i);
    en[i] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic load(int i, logic [15:0] a, logic [15:0] d);
    ld[i] = 1'b1; ld_addr[i] = a; ld_data[i] = d;
    @(posedge clk); #1;
    ld[i] = 1'b0;
  endtask

  // ---------------- global bound ----------------
  initial begin
    #400000;
    total++; bad++;
    $display("FAIL global_timeout: got no finish want finish before 400000");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int          lat, acc1, acc2, cnt;
    logic [15:0] d;
    logic        o;
    logic [15:0] pool [8];

    for (int i = 0; i < 2; i++) begin
      en[i] = 0; we[i] = 0; ld[i] = 0; addr[i] = 0; din[i] = 0; ld_addr[i] = 0; ld_data[i] = 0;
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_dout", dout_s[0], 16'h0000);
    check("reset_rdy", 16'(rdy_s[0]), 16'h0000);
    @(posedge clk); #1;

    // Backdoor load then read, 2 wait states; 0x3000 is outside a 4K RAM.
    load(0, 16'h0300, 16'h1234);
    load(0, 16'h3000, 16'h9999);
    start_req(0, 0, 16'h0300, 16'h0);
    wait_rdy(0, lat, d, o);
    check("rd_lat", 16'(lat), 16'd3);
    check("rd_data", d, 16'h1234);
    check("rd_oor", 16'(o), 16'h0);
    idle(0);
    start_req(0, 0, 16'h3000, 16'h0);
    wait_rdy(0, lat, d, o);
    check("oor_load_rd", d, 16'h0000);
    check("oor_load_flag", 16'(o), 16'h1);
    idle(0);

    // Write then back-to-back read.
    acc1 = ek + 1;
    start_req(0, 1, 16'h0005, 16'hBEEF);
    wait_rdy(0, lat, d, o);
    check("wr_dout_hold", d, 16'h0000);
    acc2 = ek + 1;
    start_req(0, 0, 16'h0005, 16'h0);
    wait_rdy(0, lat, d, o);
    check("b2b_rd_data", d, 16'hBEEF);
    check("b2b_rd_lat", 16'(lat), 16'd3);
    check("b2b_gap", 16'(acc2 - acc1), 16'd4);
    idle(0);

    // Out-of-range write and read.
    load(0, 16'h0000, 16'h0A0A);
    start_req(0, 1, 16'h2000, 16'hFFFF);
    wait_rdy(0, lat, d, o);
    check("oor_wr_flag", 16'(o), 16'h1);
    check("oor_wr_dout", d, 16'hBEEF);
    idle(0);
    start_req(0, 0, 16'h2000, 16'h0);
    wait_rdy(0, lat, d, o);
    check("oor_rd_flag", 16'(o), 16'h1);
    check("oor_rd_data", d, 16'h0000);
    idle(0);
    start_req(0, 0, 16'h0000, 16'h0);
    wait_rdy(0, lat, d, o);
    check("idx0_intact", d, 16'h0A0A);
    idle(0);

    // Load and core request in the same IDLE cycle.
    ld[0] = 1'b1; ld_addr[0] = 16'h0040; ld_data[0] = 16'h4444;
    start_req(0, 0, 16'h0040, 16'h0);
    @(posedge clk); #1;
    ld[0] = 1'b0;
    wait_rdy(0, lat, d, o);
    check("ldprio_lat_after_load", 16'(lat), 16'd3);
    check("ldprio_data", d, 16'h4444);
    idle(0);

    // Reset during WAIT aborts a write.
    load(0, 16'h0010, 16'h5555);
    start_req(0, 1, 16'h0010, 16'hAAAA);
    @(posedge clk); #1;
    rst = 1'b0; en[0] = 1'b0;
    @(negedge clk);
    check("rstw_rdy", 16'(rdy_s[0]), 16'h0);
    check("rstw_dout", dout_s[0], 16'h0000);
    @(posedge clk); #1;
    rst = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (rdy_s[0] === 1'b1) cnt++;
    end
    check("rstw_no_rdy", 16'(cnt), 16'd0);
    @(posedge clk); #1;
    start_req(0, 0, 16'h0010, 16'h0);
    wait_rdy(0, lat, d, o);
    check("rstw_keep", d, 16'h5555);
    idle(0);

    // Zero wait states.
    load(1, 16'h8000, 16'h7777);
    start_req(1, 0, 16'h8000, 16'h0);
    wait_rdy(1, lat, d, o);
    check("w0_lat", 16'(lat), 16'd1);
    check("w0_data", d, 16'h7777);
    idle(1);
    start_req(1, 0, 16'h8000, 16'h0);
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (rdy_s[1] === 1'b1) cnt++;
      if (n == 2) begin
        @(posedge clk); #1;
        en[1] = 1'b0;
      end
    end
    check("w0_hold3_reqs", 16'(cnt), 16'd2);
    @(posedge clk); #1;

    // Randomised traffic on both instances, checked by the per-cycle model.
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 8; p++) begin
        pool[p] = (i == 0) ? 16'($urandom_range(0, 4095)) : 16'($urandom_range(0, 65535));
        load(i, pool[p], 16'($urandom));
      end
      for (int k = 0; k < 50; k++) begin
        logic [15:0] a;
        if (i == 0 && $urandom_range(0, 3) == 0)
          a = {4'($urandom_range(1, 15)), 12'($urandom)};
        else
          a = pool[$urandom_range(0, 7)];
        start_req(i, 1'($urandom_range(0, 1)), a, 16'($urandom));
        wait_rdy(i, lat, d, o);
        if ($urandom_range(0, 2) != 0) begin
          idle(i);
          if ($urandom_range(0, 3) == 0) load(i, pool[$urandom_range(0, 7)], 16'($urandom));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
      end
      idle(i);
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
